// File: rtl/cryptochip_serial_pkg.sv
// Shared types and constants for the serial message receive path.
package cryptochip_serial_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam logic        START_BIT          = 1'b1;
    localparam int unsigned DEFAULT_WORD_WIDTH = 32;

endpackage

// File: rtl/ser_shift_reg.sv
// Serial-to-parallel shift register with running XOR of the bits shifted since the last clear.
// MSB_FIRST=1 shifts toward the MSB so the first bit ends in [WORD_WIDTH-1].
module ser_shift_reg #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_clr,
    input  logic                  i_shift_en,
    input  logic                  i_bit,
    output logic [WORD_WIDTH-1:0] o_data_next_c,
    output logic                  o_parity
);

    logic [WORD_WIDTH-1:0] r_data;
    logic                  r_parity;
    logic [WORD_WIDTH-1:0] w_shifted;

    if (MSB_FIRST) begin : g_msb_first
        assign w_shifted = {r_data[WORD_WIDTH-2:0], i_bit};
    end else begin : g_lsb_first
        assign w_shifted = {i_bit, r_data[WORD_WIDTH-1:1]};
    end

    // Next-cycle contents, exposed so the final bit can be captured on the edge that samples it.
    always_comb begin
        o_data_next_c = r_data;
        if (i_clr) begin
            o_data_next_c = '0;
        end else if (i_shift_en) begin
            o_data_next_c = w_shifted;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data   <= '0;
            r_parity <= 1'b0;
        end else begin
            r_data <= o_data_next_c;
            if (i_clr) begin
                r_parity <= 1'b0;
            end else if (i_shift_en) begin
                r_parity <= r_parity ^ i_bit;
            end
        end
    end

    assign o_parity = r_parity;

endmodule

// File: rtl/msg_deserializer.sv
// Serial frame receiver: start bit, WORD_WIDTH data bits, optional even parity, valid/ready word port.
// Optional feature macro: PARITY_CHECK_EN adds a trailing even-parity bit and the parity_err flag.
module msg_deserializer
    import cryptochip_serial_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ser_in,
    input  logic                  ser_valid,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  busy,
    output logic                  overrun,
    output logic                  parity_err,
    input  logic                  clear_err
);

    localparam int unsigned          CNT_W    = $clog2(WORD_WIDTH);
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(WORD_WIDTH - 1);

    state_e                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [WORD_WIDTH-1:0] r_word;
    logic                  r_word_valid;
    logic                  r_busy;
    logic                  r_overrun;
    logic                  r_parity_err;

    logic                  w_start;
    logic                  w_shift_en;
    logic                  w_done;
    logic                  w_bad_parity;
    logic                  w_accept;
    logic                  w_full;
    logic                  w_xfer;
    logic [WORD_WIDTH-1:0] w_data_next;
    logic                  w_parity;

    assign w_start    = (r_state == IDLE) && ser_valid && (ser_in == START_BIT);
    assign w_shift_en = (r_state == DATA) && ser_valid;

`ifdef PARITY_CHECK_EN
    assign w_done       = (r_state == PARITY) && ser_valid;
    assign w_bad_parity = w_done && (w_parity ^ ser_in);
`else
    logic w_parity_unused;
    assign w_done          = w_shift_en && (r_cnt == LAST_CNT);
    assign w_bad_parity    = 1'b0;
    assign w_parity_unused = w_parity;
`endif

    assign w_accept = w_done && !w_bad_parity;
    assign w_full   = r_word_valid && !word_ready;
    assign w_xfer   = r_word_valid && word_ready;

    ser_shift_reg #(
        .WORD_WIDTH (WORD_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_shift (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_clr         (w_start),
        .i_shift_en    (w_shift_en),
        .i_bit         (ser_in),
        .o_data_next_c (w_data_next),
        .o_parity      (w_parity)
    );

    // Frame FSM, holding register and sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= DATA;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                DATA: begin
                    if (w_shift_en) begin
                        if (r_cnt == LAST_CNT) begin
                            r_cnt <= '0;
`ifdef PARITY_CHECK_EN
                            r_state <= PARITY;
`else
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
`endif
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (ser_valid) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // A completed word only replaces the holding register when it is empty or draining.
            if (w_accept && !w_full) begin
                r_word       <= w_data_next;
                r_word_valid <= 1'b1;
            end else if (w_xfer) begin
                r_word_valid <= 1'b0;
            end

            r_overrun    <= (w_accept && w_full) || (r_overrun && !clear_err);
            r_parity_err <= w_bad_parity || (r_parity_err && !clear_err);
        end
    end

    assign word_out   = r_word;
    assign word_valid = r_word_valid;
    assign busy       = r_busy;
    assign overrun    = r_overrun;
    assign parity_err = r_parity_err;

endmodule

// File: tb/tb_msg_deserializer.sv
// Directed scoreboard bench for msg_deserializer (default build; parity steps under PARITY_CHECK_EN).
module tb_msg_deserializer;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         ser_in;
    logic         ser_valid;
    logic         word_ready;
    logic         clear_err;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         busy;
    logic         overrun;
    logic         parity_err;

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] sb_q[$];

    always #5 clk = ~clk;

    msg_deserializer #(
        .WORD_WIDTH (W),
        .MSB_FIRST  (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err),
        .clear_err  (clear_err)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop the scoreboard on every accepted transfer.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && word_valid === 1'b1 && word_ready === 1'b1) begin
            total++;
            assert (sb_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_word observed=%h expected=none", word_out);
            end
            if (sb_q.size() != 0) chk("word_out", word_out, sb_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic v);
        ser_in    = b;
        ser_valid = v;
        step();
    endtask

    task automatic send_frame(input logic [W-1:0] w, input bit gap, input bit flip_par, input bit chk_busy);
        logic b;
        int   n;
`ifdef PARITY_CHECK_EN
        n = W + 2;
`else
        n = W + 1;
`endif
        for (int i = 0; i < n; i++) begin
            if (i == 0)      b = 1'b1;
            else if (i <= W) b = w[W-i];
            else             b = (^w) ^ flip_par;
            send_bit(b, 1'b1);
            if (i != n - 1) begin
                if (chk_busy) chk("busy_in_frame", W'(busy), W'(1));
                if (gap) begin
                    send_bit(1'($urandom), 1'b0);
                    if (chk_busy) chk("busy_in_gap", W'(busy), W'(1));
                end
            end
        end
        ser_valid = 1'b0;
        if (chk_busy) chk("busy_after_frame", W'(busy), W'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_word_out"},   word_out,          W'(0));
        chk({tag, "_word_valid"}, W'(word_valid),    W'(0));
        chk({tag, "_busy"},       W'(busy),          W'(0));
        chk({tag, "_overrun"},    W'(overrun),       W'(0));
        chk({tag, "_parity_err"}, W'(parity_err),    W'(0));
    endtask

    initial begin
        reset_n    = 1'b0;
        ser_in     = 1'b0;
        ser_valid  = 1'b0;
        word_ready = 1'b0;
        clear_err  = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");
        reset_n = 1'b1;
        step();

        // Continuous frame, consumer always ready.
        word_ready = 1'b1;
        sb_q.push_back(32'hDEADBEEF);
        send_frame(32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        chk("t1_valid_after_last", W'(word_valid), W'(1));
        chk("t1_word", word_out, 32'hDEADBEEF);
        step();
        chk("t1_valid_one_cycle", W'(word_valid), W'(0));
        chk("t1_sb_empty", W'(sb_q.size()), W'(0));

        // Same frame with ser_valid stalls between bits.
        sb_q.push_back(32'hDEADBEEF);
        send_frame(32'hDEADBEEF, 1'b1, 1'b0, 1'b1);
        chk("t2_valid", W'(word_valid), W'(1));
        step();
        chk("t2_valid_drop", W'(word_valid), W'(0));

        // Back-to-back frames into a full holding register.
        word_ready = 1'b0;
        sb_q.push_back(32'h00000001);
        send_frame(32'h00000001, 1'b0, 1'b0, 1'b0);
        send_frame(32'h80000000, 1'b0, 1'b0, 1'b0);
        chk("t3_overrun", W'(overrun), W'(1));
        chk("t3_valid_held", W'(word_valid), W'(1));
        chk("t3_word_kept", word_out, 32'h00000001);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("t3_overrun_clr", W'(overrun), W'(0));
        chk("t3_valid_still", W'(word_valid), W'(1));
        word_ready = 1'b1;
        step();
        chk("t3_valid_drained", W'(word_valid), W'(0));
        chk("t3_sb_empty", W'(sb_q.size()), W'(0));

        // Reset asserted mid-frame after 10 data bits.
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom), 1'b1);
        ser_valid = 1'b0;
        chk("t4_busy_before", W'(busy), W'(1));
        reset_n = 1'b0;
        #1;
        chk_all_zero("t4_async");
        step();
        reset_n = 1'b1;
        step();
        sb_q.push_back(32'h12345678);
        send_frame(32'h12345678, 1'b0, 1'b0, 1'b0);
        chk("t4_valid", W'(word_valid), W'(1));
        step();
        chk("t4_sb_empty", W'(sb_q.size()), W'(0));

`ifdef PARITY_CHECK_EN
        // Good parity accepted, bad parity dropped and flagged.
        sb_q.push_back(32'h00000003);
        send_frame(32'h00000003, 1'b0, 1'b0, 1'b0);
        chk("t5_good_valid", W'(word_valid), W'(1));
        chk("t5_good_perr", W'(parity_err), W'(0));
        step();
        send_frame(32'h00000003, 1'b0, 1'b1, 1'b0);
        chk("t5_bad_perr", W'(parity_err), W'(1));
        chk("t5_bad_valid", W'(word_valid), W'(0));
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("t5_perr_clr", W'(parity_err), W'(0));
`endif

        // Idle line low with ser_valid asserted.
        ser_in    = 1'b0;
        ser_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("t6_busy", W'(busy), W'(0));
            chk("t6_valid", W'(word_valid), W'(0));
        end
        ser_valid = 1'b0;

        // Random words back to back.
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] w;
            w = W'($urandom);
            sb_q.push_back(w);
            send_frame(w, 1'b0, 1'b0, 1'b0);
        end
        repeat (3) step();
        chk("t7_sb_empty", W'(sb_q.size()), W'(0));
        chk("t7_no_overrun", W'(overrun), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
